// File: rtl/mod_pkg.sv
// Shared definitions for the single-wire bus master: command codes, FSM
// states and the slot timing constants (all in ticks).
package mod_pkg;

   typedef enum logic [1:0] {
      CMD_RESET = 2'b00,
      CMD_WRITE = 2'b01,
      CMD_READ  = 2'b10
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      RST_LOW,
      RST_WAIT,
      SLOT_LOW,
      SLOT_REL,
      DONE
   } state_t;

   localparam int T_RST_LOW   = 480;
   localparam int T_PRES      = 70;
   localparam int T_RST_REL   = 480;
   localparam int T_SLOT      = 65;
   localparam int T_W1_LOW    = 6;
   localparam int T_W0_LOW    = 60;
   localparam int T_RD_LOW    = 6;
   localparam int T_RD_SAMPLE = 15;

   // Number of ticks the master holds the line low at the start of a slot.
   function automatic int slot_low_ticks(input cmd_t c, input logic bit_val);
      if (c == CMD_WRITE && !bit_val) begin
         return T_W0_LOW;
      end else if (c == CMD_WRITE) begin
         return T_W1_LOW;
      end else begin
         return T_RD_LOW;
      end
   endfunction

endpackage

// File: rtl/mod_tick.sv
// Timing tick divider. Pulses tick once every TICK_DIV clocks; tick_pre is
// high in the cycle just before each tick so callers can finish one cycle
// early. restart realigns the phase so the first tick lands TICK_DIV cycles
// after the restart cycle.
module mod_tick #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick,
   output logic tick_pre
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] div_cnt_reg;

   // Free-running divider counter with synchronous phase restart.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_reg <= '0;
      end else if (restart || div_cnt_reg == CW'(TICK_DIV - 1)) begin
         div_cnt_reg <= '0;
      end else begin
         div_cnt_reg <= div_cnt_reg + 1'b1;
      end
   end

   assign tick     = (div_cnt_reg == CW'(TICK_DIV - 1));
   assign tick_pre = (div_cnt_reg == CW'(TICK_DIV - 2));

endmodule

// File: rtl/mod_unit.sv
// Open-drain single-wire bus master. Runs one reset/presence, write-byte or
// read-byte command at a time, generating slot timing on the shared line
// and returning presence status and read data to the host.
module mod_unit
   import mod_pkg::*;
#(
   parameter int TICK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire        w,
   input  logic [1:0] cmd,
   input  logic       start,
   input  logic [7:0] din,
   output logic       busy,
   output logic       done,
   output logic [7:0] dout,
   output logic       presence
);

   state_t      state_reg, state_next;
   cmd_t        cmd_reg;
   logic [7:0]  din_reg;
   logic [7:0]  rx_reg;
   logic [2:0]  bit_cnt_reg;
   logic [8:0]  tick_cnt_reg;
   logic [1:0]  sync_reg;
   logic [1:0]  sample_pipe_reg;

   logic        tick, tick_pre;
   logic        accept;
   logic        tick_clr;
   logic        bit_inc;
   logic        drive_low;
   logic        sample_evt;
   logic        last_slot;
   logic [8:0]  low_end;

   // Only legal command codes are accepted, and only from IDLE.
   assign accept    = (state_reg == IDLE) && start && (cmd != 2'b11);
   assign last_slot = (bit_cnt_reg == 3'd7);
   assign low_end   = 9'(slot_low_ticks(cmd_reg, din_reg[bit_cnt_reg]) - 1);

   // The line is only ever pulled low or released; reset releases it at once.
   assign w = (drive_low && !rst) ? 1'b0 : 1'bz;

   mod_tick #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (accept),
      .tick    (tick),
      .tick_pre(tick_pre)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and line/handshake outputs. The final phase of every command
   // ends on tick_pre so the DONE cycle coincides with the closing tick.
   always_comb begin
      state_next = state_reg;
      tick_clr   = 1'b0;
      bit_inc    = 1'b0;
      drive_low  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = (cmd == CMD_RESET) ? RST_LOW : SLOT_LOW;
            end
         end
         RST_LOW: begin
            busy      = 1'b1;
            drive_low = 1'b1;
            if (tick && tick_cnt_reg == 9'(T_RST_LOW - 1)) begin
               state_next = RST_WAIT;
               tick_clr   = 1'b1;
            end
         end
         RST_WAIT: begin
            busy = 1'b1;
            if (tick_pre && tick_cnt_reg == 9'(T_RST_REL - 1)) begin
               state_next = DONE;
            end
         end
         SLOT_LOW: begin
            busy      = 1'b1;
            drive_low = 1'b1;
            if (tick && tick_cnt_reg == low_end) begin
               state_next = SLOT_REL;
            end
         end
         SLOT_REL: begin
            busy = 1'b1;
            if (last_slot && tick_pre && tick_cnt_reg == 9'(T_SLOT - 1)) begin
               state_next = DONE;
            end else if (!last_slot && tick && tick_cnt_reg == 9'(T_SLOT - 1)) begin
               state_next = SLOT_LOW;
               tick_clr   = 1'b1;
               bit_inc    = 1'b1;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Command latch, per-phase tick counter and bit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_reg      <= CMD_RESET;
         din_reg      <= '0;
         bit_cnt_reg  <= '0;
         tick_cnt_reg <= '0;
      end else if (accept) begin
         cmd_reg      <= cmd_t'(cmd);
         din_reg      <= din;
         bit_cnt_reg  <= '0;
         tick_cnt_reg <= '0;
      end else begin
         if (tick_clr) begin
            tick_cnt_reg <= '0;
         end else if (tick && state_reg != IDLE) begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
         end
         if (bit_inc) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
         end
      end
   end

   // Two-flop synchronizer for the externally driven line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], w};
      end
   end

   // Sample strobe fires on the sampling tick; it is delayed two cycles so
   // the synchronized value corresponds to the line at that tick.
   assign sample_evt = tick &&
      ((state_reg == RST_WAIT && tick_cnt_reg == 9'(T_PRES - 1)) ||
       (state_reg == SLOT_REL && cmd_reg == CMD_READ &&
        tick_cnt_reg == 9'(T_RD_SAMPLE - 1)));

   // Sample capture into presence / receive shift register, and dout update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_pipe_reg <= '0;
         rx_reg          <= '0;
         dout            <= '0;
         presence        <= 1'b0;
      end else begin
         sample_pipe_reg <= {sample_pipe_reg[0], sample_evt};
         if (sample_pipe_reg[1]) begin
            if (cmd_reg == CMD_RESET) begin
               presence <= ~sync_reg[1];
            end else if (cmd_reg == CMD_READ) begin
               rx_reg[bit_cnt_reg] <= sync_reg[1];
            end
         end
         if (state_next == DONE && state_reg != DONE && cmd_reg == CMD_READ) begin
            dout <= rx_reg;
         end
      end
   end

endmodule

// File: tb/tb_mod_unit.sv
// Directed bench for mod_unit: reset/presence with and without a slave,
// byte write slot widths, byte read with a slave model, ignored starts,
// and a mid-command reset.
module tb_mod_unit;

   localparam int TD = 4;
   localparam int RST_CYC  = 960 * TD;
   localparam int BYTE_CYC = 8 * 65 * TD;

   logic       clk;
   logic       rst;
   logic [1:0] cmd;
   logic       start;
   logic [7:0] din;
   logic       busy;
   logic       done;
   logic [7:0] dout;
   logic       presence;
   logic       slave_low;
   wire        w_line;

   pullup (w_line);
   assign w_line = slave_low ? 1'b0 : 1'bz;

   mod_unit #(
      .TICK_DIV(TD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .w       (w_line),
      .cmd     (cmd),
      .start   (start),
      .din     (din),
      .busy    (busy),
      .done    (done),
      .dout    (dout),
      .presence(presence)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int passed;
   int fails;
   int done_count;
   int run_len;
   int runs[$];
   int cyc;
   int dc0;
   logic [7:0] wexp;

   // Count done pulses and record lengths of low periods on the line.
   always @(negedge clk) begin
      if (done === 1'b1) done_count++;
      if (w_line === 1'b0) begin
         run_len++;
      end else if (run_len != 0) begin
         runs.push_back(run_len);
         run_len = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] c, input logic [7:0] d);
      @(posedge clk); #1;
      cmd = c; din = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Called in the first busy cycle; returns in the done cycle (or on timeout).
   task automatic wait_done(input int limit, output int cycles);
      cycles = 1;
      while (done !== 1'b1 && cycles < limit + 64) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic slave_reset();
      repeat ((480 + 15) * TD) @(posedge clk);
      #1 slave_low = 1'b1;
      repeat ((240 - 15) * TD) @(posedge clk);
      #1 slave_low = 1'b0;
   endtask

   task automatic slave_read(input logic [7:0] val);
      for (int k = 0; k < 8; k++) begin
         if (!val[k]) begin
            slave_low = 1'b1;
            repeat (30 * TD) @(posedge clk);
            #1 slave_low = 1'b0;
            repeat (35 * TD) @(posedge clk);
            #1;
         end else begin
            repeat (65 * TD) @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      total = 0; passed = 0; fails = 0; done_count = 0; run_len = 0;
      rst = 1'b1; cmd = 2'b00; start = 1'b0; din = 8'h00; slave_low = 1'b0;
      wexp = 8'hA5;

      // Reset values
      repeat (3) @(posedge clk); #1;
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);
      check("rst_dout", {24'b0, dout}, 8'h00);
      check("rst_presence", {31'b0, presence}, 0);
      check("rst_line", {31'b0, w_line}, 1);
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Reset command, no slave
      runs.delete();
      dc0 = done_count;
      issue(2'b00, 8'h00);
      check("nos_busy_n1", {31'b0, busy}, 1);
      check("nos_line_n1", {31'b0, w_line}, 0);
      wait_done(RST_CYC, cyc);
      $display("reset/no-slave: %0d cycles presence=%0d", cyc, presence);
      check("nos_duration", cyc, RST_CYC);
      check("nos_done_busy", {31'b0, busy}, 0);
      check("nos_presence", {31'b0, presence}, 0);
      check("nos_line_after", {31'b0, w_line}, 1);
      check("nos_runs", runs.size(), 1);
      check("nos_low_width", runs[0], 480 * TD);
      @(posedge clk); #1;
      check("nos_done_once", done_count - dc0, 1);

      // Read 0x3C with slave
      repeat (3) @(posedge clk); #1;
      dc0 = done_count;
      issue(2'b10, 8'h00);
      check("rd_busy_n1", {31'b0, busy}, 1);
      fork
         begin
            wait_done(BYTE_CYC, cyc);
            $display("read: %0d cycles dout=%02h", cyc, dout);
            check("rd_duration", cyc, BYTE_CYC);
            check("rd_dout", {24'b0, dout}, 8'h3C);
            check("rd_done_busy", {31'b0, busy}, 0);
         end
         slave_read(8'h3C);
      join
      check("rd_done_once", done_count - dc0, 1);

      // Write 0xA5 with start pulses during busy and in the done cycle
      repeat (3) @(posedge clk); #1;
      runs.delete();
      dc0 = done_count;
      issue(2'b01, 8'hA5);
      fork
         begin
            wait_done(BYTE_CYC, cyc);
            $display("write A5: %0d cycles", cyc);
            check("wr_duration", cyc, BYTE_CYC);
            check("wr_dout_kept", {24'b0, dout}, 8'h3C);
         end
         begin
            repeat (100) @(posedge clk); #1;
            cmd = 2'b10; din = 8'hFF; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      join
      cmd = 2'b01; din = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("done_cycle_start_ignored", {31'b0, busy}, 0);
      check("wr_done_once", done_count - dc0, 1);
      check("wr_runs", runs.size(), 8);
      for (int k = 0; k < 8; k++) begin
         $display("write slot %0d: low %0d cycles", k, runs[k]);
         check($sformatf("wr_slot%0d_width", k), runs[k], wexp[k] ? 6 * TD : 60 * TD);
      end

      // Reserved command is ignored
      dc0 = done_count;
      issue(2'b11, 8'h55);
      check("cmd11_busy", {31'b0, busy}, 0);
      repeat (20) @(posedge clk); #1;
      check("cmd11_line", {31'b0, w_line}, 1);
      check("cmd11_no_done", done_count - dc0, 0);

      // Reset command with slave presence pulse
      runs.delete();
      dc0 = done_count;
      issue(2'b00, 8'h00);
      fork
         begin
            wait_done(RST_CYC, cyc);
            $display("reset/slave: %0d cycles presence=%0d", cyc, presence);
            check("pres_duration", cyc, RST_CYC);
            check("pres_presence", {31'b0, presence}, 1);
         end
         slave_reset();
      join
      check("pres_runs", runs.size(), 2);
      check("pres_master_low", runs[0], 480 * TD);
      check("pres_slave_low", runs[1], 225 * TD);

      // Reset in the middle of a write-0 slot
      repeat (3) @(posedge clk); #1;
      issue(2'b01, 8'h00);
      repeat (30 * TD - 1) @(posedge clk);
      #1;
      check("mid_line_low", {31'b0, w_line}, 0);
      rst = 1'b1;
      #1;
      $display("mid-command reset: line=%0b busy=%0b", w_line, busy);
      check("mid_line_released", {31'b0, w_line}, 1);
      check("mid_busy", {31'b0, busy}, 0);
      check("mid_done", {31'b0, done}, 0);
      check("mid_dout", {24'b0, dout}, 8'h00);
      check("mid_presence", {31'b0, presence}, 0);
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Next command after reset runs normally
      dc0 = done_count;
      issue(2'b10, 8'h00);
      check("post_busy_n1", {31'b0, busy}, 1);
      fork
         begin
            wait_done(BYTE_CYC, cyc);
            $display("read after reset: %0d cycles dout=%02h", cyc, dout);
            check("post_duration", cyc, BYTE_CYC);
            check("post_dout", {24'b0, dout}, 8'h5A);
         end
         slave_read(8'h5A);
      join
      check("post_done_once", done_count - dc0, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mod_unit.md
# mod_unit

Open-drain single-wire bus master (1-Wire-style) that drives and samples one shared, externally pulled-up line. A host issues one command at a time: reset/presence, write byte, or read byte. The block generates the bit-slot timing on the line and returns read data and presence status. It sits between a host register interface and the board-level pulled-up wire.

## Interface
Parameters:
- TICK_DIV, 4, clock cycles per timing tick (≥2); all slot timings are counted in ticks.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- w  inout  1  shared line with external pull-up; block drives only 0 or Z, never 1.
- cmd  in  2  00 = reset/presence, 01 = write byte, 10 = read byte, 11 = reserved.
- start  in  1  command strobe; accepted only when busy=0.
- din  in  8  write data, captured on accepted start.
- busy  out  1  high from cycle after accept until done.
- done  out  1  one-cycle pulse at command completion.
- dout  out  8  read data, valid from done until next read completes.
- presence  out  1  result of last reset command (1 = slave answered).

## Operation
- Line output: w = 0 when internal drive_low = 1, else Z. Line input is sampled through a 2-flop synchronizer before use.
- Tick generator: free-running divider pulses `tick` every TICK_DIV clocks; it restarts at command accept so slot timing is phase-aligned.
- FSM states: IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_REL, DONE.
- IDLE:
  - Line is released.
  - start=1 with cmd 00/01/10 latches cmd and din, clears the bit counter and goes to RST_LOW (00) or SLOT_LOW (01/10).
  - cmd 11 is ignored: no busy, no done.
- Reset (ticks):
  - Drive low 480 ticks (RST_LOW), then release.
  - In RST_WAIT, sample the line at release+70 ticks; presence = (sample == 0).
  - Finish at release+480 ticks, then DONE.
- Write slot per bit, LSB first:
  - Bit=1: low 6 ticks, released to 65.
  - Bit=0: low 60 ticks, released to 65.
  - Line is released for the last 5 ticks minimum (recovery).
- Read slot per bit, LSB first:
  - Low 6 ticks, release, sample at tick 15.
  - Shift the sample into bit position, then end the slot at tick 65.
- After 8 slots, go to DONE. A read updates dout with the assembled byte in the DONE cycle; a write leaves dout unchanged.
- DONE: done=1 for one cycle, busy=0 in that same cycle, then IDLE. A start in the DONE cycle is ignored.
- start while busy=1 is ignored, and din is not re-latched.

## Timing
- Reset values: busy=0, done=0, dout=0x00, presence=0, line released (Z), FSM=IDLE.
- rst asserted mid-command releases the line combinationally; no partial done is generated.
- Accept latency: start at cycle N gives busy=1 and drive_low=1 at cycle N+1.
- Command durations (cycles, from the first busy cycle to the done cycle inclusive):
  - Reset: 960·TICK_DIV.
  - Byte: 8·65·TICK_DIV.
- Sample points are taken at the specified tick plus 2 cycles of synchronizer delay. Slaves must hold the line stable ±1 tick around each sample point.
- Line held low externally during a write-1 slot: no error; the block does not check this.

## Structure
- Shared package mod_pkg holds:
  - cmd encoding enum (CMD_RESET, CMD_WRITE, CMD_READ).
  - FSM state enum.
  - Tick constants: T_RST_LOW=480, T_PRES=70, T_RST_REL=480, T_SLOT=65, T_W1_LOW=6, T_W0_LOW=60, T_RD_LOW=6, T_RD_SAMPLE=15.
- Sub-module mod_tick: TICK_DIV divider with synchronous restart input; outputs `tick`.
- Top level holds the synchronizer, tick counter, bit counter, shift register and FSM.

## Test plan
- Reset command with slave model pulling low 15–240 ticks after release -> presence=1, done after 960·TICK_DIV cycles, line low exactly 480 ticks.
- Reset command with no slave -> presence=0; line stays high after release.
- Write 0xA5 -> per-slot low widths 6,60,6,60,60,6,60,6 ticks (LSB first); dout unchanged.
- Read with slave driving bits of 0x3C during slots -> dout=0x3C at done; busy drops in the done cycle.
- start pulses during busy and cmd=11 in IDLE -> ignored; no extra done, din not re-latched.
- rst asserted at tick 30 of a write-0 slot -> line released immediately; all outputs return to reset values; the next command runs normally.
